ndma_rd_engine: RTL
===================

Name: ndma_rd_engine

Overview:
- Source-side read engine of the NanoDMA datapath.
- On a start pulse it issues a burst of word reads on an OBI manager port and pushes every returned word into the internal data FIFO. The FIFO in turn feeds the write manager.
- It throttles issuance with a credit check against FIFO free space, because OBI responses cannot be back-pressured. It reports completion and bus errors to the config/IRQ logic.

Parameters:
MaxTxSize, 256, maximal transfer length in words; LenBits = $clog2(MaxTxSize)+1
MaxOutstanding, 2, maximal granted-but-unanswered reads; OutBits = $clog2(MaxOutstanding+1)
FifoDepth, 4, depth of downstream FIFO; FreeBits = $clog2(FifoDepth+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle start pulse, sampled only in IDLE
src_addr_i  in  32  source byte address, bits [1:0] ignored
len_i  in  LenBits  transfer length in words, 0..MaxTxSize
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky OBI error flag, cleared on accepted start
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  32  OBI address
obi_we_o  out  1  constant 0
obi_be_o  out  4  constant 4'hF
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  32  OBI read data
obi_err_i  in  1  OBI response error, qualified by rvalid
fifo_free_i  in  FreeBits  current free FIFO slots; updates the cycle after a push/pop
fifo_push_o  out  1  FIFO push
fifo_data_o  out  32  FIFO push data

Behaviour:
- Reset:
  - State IDLE; all counters, address and err 0.
  - busy_o = done_o = err_o = obi_req_o = fifo_push_o = 0; obi_addr_o = 0.
  - Reset asserted mid-transfer aborts immediately. In-flight responses arriving after reset release are ignored, because rvalid is only honoured outside IDLE.
- Registers:
  - addr_q (32b).
  - issue_rem_q (LenBits): reads still to issue.
  - recv_rem_q (LenBits): responses still expected.
  - out_q (OutBits): outstanding reads.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start_i with len_i != 0: load addr_q = {src_addr_i[31:2],2'b00}, issue_rem_q = recv_rem_q = len_i; clear err; go to ISSUE. busy_o rises next cycle.
  - start_i with len_i == 0: done_o = 1 on the next cycle; stay IDLE; err cleared.
  - start_i while not in IDLE is ignored.
- ISSUE:
  - obi_req_o = (issue_rem_q != 0) && (out_q < MaxOutstanding) && (out_q < fifo_free_i). Combinational from registers and fifo_free_i only; never from gnt.
  - obi_addr_o = addr_q.
  - On req && gnt: addr_q += 4 (wraps modulo 2^32); issue_rem_q -= 1.
  - When the issue_rem_q decrement reaches 0 -> DRAIN.
- Request stability:
  - The credit terms cannot fall while req is pending. out_q only falls; free falls only by pushes that decrement out_q equally. Hence req is never retracted before gnt and addr is stable.
  - This is an RTL assertion.
- Outstanding accounting: out_q_d = out_q + (req&&gnt) - (rvalid accepted). Simultaneous grant and response in the same cycle leaves out_q unchanged.
- Response handling, in ISSUE or DRAIN:
  - When obi_rvalid_i: fifo_push_o = 1 and fifo_data_o = obi_rdata_i in the same cycle (0 latency, combinational); recv_rem_q -= 1.
  - If obi_err_i also: err set; the data is still pushed.
- DRAIN: when a response makes recv_rem_q reach 0 -> IDLE, with done_o pulsed the following cycle and busy_o falling the same cycle. Each transfer produces exactly one done_o pulse.
- Ordering and occupancy:
  - Responses return in order; the engine never pushes more than len_i words.
  - With fifo_free_i == 0, no request is issued.
  - FIFO never overflows by construction.

Test Plan:
- Basic: src 0x1000, len 4, gnt always 1, rvalid 1 cycle after gnt, FIFO free 4 -> addrs 0x1000/04/08/0C; 4 pushes in order; done_o one pulse; out_q never exceeds 2.
- Back-pressure: free held 0 for 10 cycles, then 1 -> no req while 0; then exactly 1 request until free rises; no push when free was 0 at issue.
- Grant stall: gnt low 5 cycles -> req and addr held stable; count checked by assertion.
- Error and edge cases: obi_err_i on word 2 of 3 -> err_o set; all 3 words pushed; done_o pulses. Next start clears err_o. len 0 -> done_o next cycle, no req. src 0xFFFFFFFC, len 2 -> second addr 0x00000000.
- Reset mid-transfer: rst_ni low during DRAIN with 1 outstanding -> outputs 0, IDLE. A late rvalid after release produces no push. A new start works normally.

Source files
------------

// File: rtl/ndma_rd_engine.sv
// NanoDMA source-side read engine: issues word reads on an OBI manager port and
// pushes every response into the downstream FIFO, throttled by FIFO free space.
module ndma_rd_engine #(
    parameter int unsigned MaxTxSize      = 256,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned FifoDepth      = 4,
    localparam int unsigned LenBits  = $clog2(MaxTxSize) + 1,
    localparam int unsigned OutBits  = $clog2(MaxOutstanding + 1),
    localparam int unsigned FreeBits = $clog2(FifoDepth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [LenBits-1:0]  len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [31:0]         obi_addr_o,
    output logic                obi_we_o,
    output logic [3:0]          obi_be_o,
    input  logic                obi_rvalid_i,
    input  logic [31:0]         obi_rdata_i,
    input  logic                obi_err_i,
    input  logic [FreeBits-1:0] fifo_free_i,
    output logic                fifo_push_o,
    output logic [31:0]         fifo_data_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e              state_q;
    logic [31:0]         addr_q;
    logic [LenBits-1:0]  issue_rem_q;
    logic [LenBits-1:0]  recv_rem_q;
    logic [OutBits-1:0]  out_q;
    logic [OutBits-1:0]  out_d;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                grant;
    logic                resp;
    logic                unused_addr_lsbs;

    assign unused_addr_lsbs = ^src_addr_i[1:0];

    // Credit check: every outstanding read needs a guaranteed FIFO slot, since
    // responses cannot be stalled.
    assign obi_req_o = (state_q == StIssue) && (issue_rem_q != '0)
                       && (32'(out_q) < MaxOutstanding)
                       && (32'(out_q) < 32'(fifo_free_i));
    assign grant     = obi_req_o && obi_gnt_i;
    // Responses are only honoured while a transfer is active.
    assign resp      = obi_rvalid_i && (state_q != StIdle);
    assign out_d     = out_q + OutBits'(grant) - OutBits'(resp);

    assign obi_addr_o  = addr_q;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = 4'hF;
    assign fifo_push_o = resp;
    assign fifo_data_o = obi_rdata_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            issue_rem_q <= '0;
            recv_rem_q  <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            if (grant) begin
                addr_q      <= addr_q + 32'd4;
                issue_rem_q <= issue_rem_q - LenBits'(1);
            end
            if (resp) begin
                recv_rem_q <= recv_rem_q - LenBits'(1);
                if (obi_err_i) begin
                    err_q <= 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i != '0) begin
                            addr_q      <= {src_addr_i[31:2], 2'b00};
                            issue_rem_q <= len_i;
                            recv_rem_q  <= len_i;
                            busy_q      <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (grant && (issue_rem_q == LenBits'(1))) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (resp && (recv_rem_q == LenBits'(1))) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A pending request must hold with a stable address until granted.
    req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (obi_req_o && !obi_gnt_i) |=> (obi_req_o && $stable(obi_addr_o)));

    out_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(out_q) <= MaxOutstanding));

endmodule
